// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory, with capped locked bursts.
// Latency: grant and memory drive are combinational; read data/rvalid are registered one cycle after the grant.
// Backpressure: a requester holds req until its gnt; the waiting side is blocked for at most MAX_BURST locked grants.
module dmem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter bit PRIO_INIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam int              CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   BMAX = CW'(MAX_BURST);

    state_t        state;
    logic          last;
    logic [CW-1:0] burst_cnt;

    logic          locked;
    logic          own;
    logic          own_req;
    logic          oth_req;
    logic          burst_full;
    logic          grant;
    logic          win;
    logic          win_lock;
    logic          win_we;
    logic [CW-1:0] cnt_nxt;

    assign locked     = (state != IDLE);
    assign own        = (state == LOCK1);
    assign own_req    = own ? req1 : req0;
    assign oth_req    = own ? req0 : req1;
    assign burst_full = (burst_cnt == BMAX);

    // Arbitration ignores reset; outputs are gated below and the flops are held in reset anyway.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (locked && own_req) begin
            grant = 1'b1;
            win   = (burst_full && oth_req) ? ~own : own;
        end else if (req0 && req1) begin
            grant = 1'b1;
            win   = ~last;
        end else if (req0 || req1) begin
            grant = 1'b1;
            win   = req1;
        end
    end

    assign win_lock = win ? lock1 : lock0;
    assign win_we   = win ? we1 : we0;

    // Continuing the same owner counts up (saturating); a new or preempting owner starts at one.
    always_comb begin
        cnt_nxt = CW'(1);
        if (locked && (win == own))
            cnt_nxt = burst_full ? BMAX : burst_cnt + CW'(1);
    end

    assign gnt0       = reset & grant & ~win;
    assign gnt1       = reset & grant & win;
    assign mem_write  = (gnt0 & we0) | (gnt1 & we1);
    assign mem_addr   = gnt1 ? addr1  : addr0;
    assign mem_datain = gnt1 ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= PRIO_INIT;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            rvalid0 <= grant & ~win & ~win_we;
            rvalid1 <= grant &  win & ~win_we;
            if (grant && !win && !win_we)
                rdata0 <= mem_dataout;
            if (grant && win && !win_we)
                rdata1 <= mem_dataout;
            if (grant) begin
                last <= win;
                if (win_lock) begin
                    state     <= win ? LOCK1 : LOCK0;
                    burst_cnt <= cnt_nxt;
                end else begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_write;
    logic [DW-1:0] rdata0, rdata1, mem_datain, mem_dataout;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .PRIO_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, write at the clock edge.
    logic [DW-1:0] env_mem [0:255];
    assign mem_dataout = env_mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) env_mem[mem_addr[7:0]] <= mem_datain;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: who owns a locked run, how long the run is, who won last.
    int            m_owner, m_run, m_last, m_w;
    logic [DW-1:0] m_mem [0:255];
    logic [1:0]    e_gnt, e_rv;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd0, e_rd1;

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1; m_w = -1;
        e_rv = 2'b00; e_rd0 = '0; e_rd1 = '0;
    endtask

    task automatic predict();
        int w;
        w = -1;
        if (reset) begin
            if (m_owner >= 0 && (m_owner == 1 ? req1 : req0)) begin
                if (m_run == MAXB && (m_owner == 1 ? req0 : req1)) w = 1 - m_owner;
                else w = m_owner;
            end else if (req0 && req1) w = 1 - m_last;
            else if (req0) w = 0;
            else if (req1) w = 1;
        end
        m_w    = w;
        e_gnt  = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        e_wr   = (w == 0) ? we0 : (w == 1) ? we1 : 1'b0;
        e_addr = (w == 1) ? addr1 : addr0;
        e_din  = (w == 1) ? wdata1 : wdata0;
    endtask

    task automatic commit();
        logic          wr, lk;
        logic [AW-1:0] a;
        e_rv = 2'b00;
        if (m_w < 0) begin
            m_owner = -1; m_run = 0;
        end else begin
            wr = (m_w == 1) ? we1 : we0;
            lk = (m_w == 1) ? lock1 : lock0;
            a  = (m_w == 1) ? addr1 : addr0;
            if (wr) m_mem[a[7:0]] = (m_w == 1) ? wdata1 : wdata0;
            else if (m_w == 1) begin e_rv = 2'b10; e_rd1 = m_mem[a[7:0]]; end
            else begin e_rv = 2'b01; e_rd0 = m_mem[a[7:0]]; end
            if (lk) begin
                m_run   = (m_owner == m_w) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
                m_owner = m_w;
            end else begin
                m_owner = -1; m_run = 0;
            end
            m_last = m_w;
        end
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic settle();
        predict();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if ({gnt1, gnt0, mem_write, rvalid1, rvalid0} !== 5'b0 || rdata0 !== '0 || rdata1 !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs got gnt=%b%b wr=%b rv=%b%b rd0=%h rd1=%h want all zero",
                         gnt1, gnt0, mem_write, rvalid1, rvalid0, rdata0, rdata1);
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 32'hA5;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) we0 = 0;
            if (i == 2) req0 = 0;
            settle();
            n_total++;
            if ({gnt1, gnt0, mem_write, mem_addr, mem_datain} !== {e_gnt, e_wr, e_addr, e_din}) begin
                n_bad++;
                $display("FAIL wr_rd_grant cyc=%0d got gnt=%b%b wr=%b a=%h d=%h want gnt=%b wr=%b a=%h d=%h",
                         i, gnt1, gnt0, mem_write, mem_addr, mem_datain, e_gnt, e_wr, e_addr, e_din);
            end
            n_total++;
            if ({rvalid1, rvalid0, rdata1, rdata0} !== {e_rv, e_rd1, e_rd0}) begin
                n_bad++;
                $display("FAIL wr_rd_read cyc=%0d got rv=%b%b rd1=%h rd0=%h want rv=%b rd1=%h rd0=%h",
                         i, rvalid1, rvalid0, rdata1, rdata0, e_rv, e_rd1, e_rd0);
            end
            if (i == 0) begin
                n_total++;
                if ({gnt0, mem_write, mem_addr} !== {1'b1, 1'b1, 16'd5}) begin
                    n_bad++;
                    $display("FAIL wr_issue got gnt0=%b wr=%b addr=%0d want 1 1 5", gnt0, mem_write, mem_addr);
                end
            end
            if (i == 2) begin
                n_total++;
                if ({rvalid0, rdata0} !== {1'b1, 32'hA5}) begin
                    n_bad++;
                    $display("FAIL rd_return got rvalid0=%b rdata0=%h want 1 000000a5", rvalid0, rdata0);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        do_reset();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            addr0 = 16'($urandom_range(0, 255)); addr1 = 16'($urandom_range(0, 255));
            settle();
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_total++;
            if ({gnt1, gnt0} !== want || {gnt1, gnt0} !== e_gnt || mem_addr !== e_addr) begin
                n_bad++;
                $display("FAIL rr_alternate cyc=%0d got gnt=%b%b addr=%h want gnt=%b addr=%h",
                         i, gnt1, gnt0, mem_addr, want, e_addr);
            end
            n_total++;
            if ({rvalid1, rvalid0, rdata1, rdata0} !== {e_rv, e_rd1, e_rd0}) begin
                n_bad++;
                $display("FAIL rr_read cyc=%0d got rv=%b%b rd1=%h rd0=%h want rv=%b rd1=%h rd0=%h",
                         i, rvalid1, rvalid0, rdata1, rdata0, e_rv, e_rd1, e_rd0);
            end
            tick();
        end
    endtask

    task automatic test_burst_preempt();
        int want_w [6] = '{1, 1, 1, 1, 0, 1};
        logic [1:0] want;
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 16'd9;
        for (int i = 0; i < 6; i++) begin
            req0 = (i >= 1 && i <= 4);
            settle();
            want = (want_w[i] == 1) ? 2'b10 : 2'b01;
            n_total++;
            if ({gnt1, gnt0} !== want || {gnt1, gnt0} !== e_gnt) begin
                n_bad++;
                $display("FAIL burst_preempt cyc=%0d got gnt=%b%b want %b", i, gnt1, gnt0, want);
            end
            tick();
        end
    endtask

    task automatic test_lock_drop();
        int want_w [4] = '{0, 0, 1, 1};
        logic [1:0] want;
        do_reset();
        req0 = 1; lock0 = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin req1 = 1; lock1 = 1; end
            req0 = (i != 2);
            settle();
            want = (want_w[i] == 1) ? 2'b10 : 2'b01;
            n_total++;
            if ({gnt1, gnt0} !== want || {gnt1, gnt0} !== e_gnt) begin
                n_bad++;
                $display("FAIL lock_drop cyc=%0d got gnt=%b%b want %b", i, gnt1, gnt0, want);
            end
            tick();
        end
    endtask

    task automatic test_reset_midread();
        clear_inputs();
        req0 = 1; addr0 = 16'd5;
        settle();
        n_total++;
        if ({gnt1, gnt0} !== 2'b01 || {gnt1, gnt0} !== e_gnt) begin
            n_bad++;
            $display("FAIL midrd_grant got gnt=%b%b want 01", gnt1, gnt0);
        end
        #1 reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({gnt1, gnt0, mem_write, rvalid1, rvalid0} !== 5'b0 || rdata0 !== '0 || rdata1 !== '0) begin
            n_bad++;
            $display("FAIL midrd_async got gnt=%b%b wr=%b rv=%b%b rd0=%h want all zero",
                     gnt1, gnt0, mem_write, rvalid1, rvalid0, rdata0);
        end
        @(posedge clk); #1;
        n_total++;
        if ({rvalid1, rvalid0} !== 2'b00 || rdata0 !== '0) begin
            n_bad++;
            $display("FAIL midrd_discard got rv=%b%b rd0=%h want 00 0", rvalid1, rvalid0, rdata0);
        end
        req1 = 1;
        reset = 1'b1;
        settle();
        n_total++;
        if ({gnt1, gnt0} !== 2'b01 || {gnt1, gnt0} !== e_gnt) begin
            n_bad++;
            $display("FAIL first_tie got gnt=%b%b want 01", gnt1, gnt0);
        end
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        clear_inputs();
        for (int i = 0; i < 600; i++) begin
            if (!req0 || m_w == 0) begin
                req0 = ($urandom_range(0, 3) != 0); we0 = $urandom_range(0, 1) == 1;
                lock0 = $urandom_range(0, 1) == 1;
                addr0 = 16'($urandom_range(0, 15)); wdata0 = $urandom;
            end
            if (!req1 || m_w == 1) begin
                req1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1) == 1;
                lock1 = $urandom_range(0, 3) != 0;
                addr1 = 16'($urandom_range(0, 15)); wdata1 = $urandom;
            end
            settle();
            n_total++;
            if ({gnt1, gnt0, mem_write, mem_addr, mem_datain} !== {e_gnt, e_wr, e_addr, e_din}) begin
                n_bad++;
                if (errs++ < 10)
                    $display("FAIL rand_grant cyc=%0d got gnt=%b%b wr=%b a=%h d=%h want gnt=%b wr=%b a=%h d=%h",
                             i, gnt1, gnt0, mem_write, mem_addr, mem_datain, e_gnt, e_wr, e_addr, e_din);
            end
            n_total++;
            if ({rvalid1, rvalid0, rdata1, rdata0} !== {e_rv, e_rd1, e_rd0}) begin
                n_bad++;
                if (errs++ < 10)
                    $display("FAIL rand_read cyc=%0d got rv=%b%b rd1=%h rd0=%h want rv=%b rd1=%h rd0=%h",
                             i, rvalid1, rvalid0, rdata1, rdata0, e_rv, e_rd1, e_rd0);
            end
            tick();
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            env_mem[i] = v;
            m_mem[i]   = v;
        end
        model_reset();
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst_preempt();
        test_lock_drop();
        test_reset_midread();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory (write/addr/datain/dataout, combinational read) between the processing core (requester 0) and the array loader/DMA (requester 1).
- Grants at most one access per cycle. Round-robin fairness, with optional locked bursts for array streaming.
- Sits between both requesters and the data memory. It is the only driver of the memory's write, addr and datain.

Parameters:
- AW, 16, address width (matches memory addr).
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive locked grants to one owner while the other requester waits (≥1).
- PRIO_INIT, 1, value of the last-winner pointer after reset; with 1, requester 0 wins the first tie.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0/req1  in  1  access request, held until granted.
- we0/we1  in  1  1 = write, 0 = read; qualified by req.
- lock0/lock1  in  1  request to keep ownership after this access.
- addr0/addr1  in  AW  access address.
- wdata0/wdata1  in  DW  write data.
- gnt0/gnt1  out  1  combinational; high in the cycle the access is issued to memory.
- rvalid0/rvalid1  out  1  registered; one-cycle pulse the cycle after a granted read.
- rdata0/rdata1  out  DW  registered read data; valid when rvalid is high, otherwise holds last value.
- mem_write  out  1  to memory write.
- mem_addr  out  AW  to memory addr.
- mem_datain  out  DW  to memory datain.
- mem_dataout  in  DW  from memory dataout.

Behaviour:

Reset (reset=0, asynchronous):
- state=IDLE, last=PRIO_INIT, burst_cnt=0.
- rvalid0/1=0, rdata0/1=0.
- gnt0/1=0 and mem_write=0 while reset is low, regardless of req.

Datapath:
- mem_addr/mem_datain are muxed from the winner's addr/wdata.
- mem_write = winner's we & gnt.
- With no grant: mem_write=0, mem_addr=addr0, mem_datain=wdata0.

Read data:
- mem_dataout is captured into the winner's rdata at the clock edge ending the grant cycle; that requester's rvalid=1 for the next cycle only.
- Read latency is 1 cycle; write completes at the grant edge.

State machine (states IDLE, LOCK0, LOCK1; burst_cnt 0..MAX_BURST):
- IDLE, one req: grant it.
- IDLE, both req: grant the requester ≠ last.
- IDLE, after a grant to w: last←w; if lockw, go to LOCKw with burst_cnt=1, else stay IDLE.
- LOCKw, reqw=1 and not (burst_cnt==MAX_BURST and req_other): grant w; burst_cnt++; stay LOCKw if lockw, else go to IDLE (lock drop ends the burst after this access).
- LOCKw, burst_cnt==MAX_BURST and req_other: preempt; grant other o; last←o; next state LOCKo (burst_cnt=1) if locko, else IDLE. w retains its req and is served later by round-robin.
- LOCKw, reqw=0: arbitrate as IDLE this cycle (grant other if requesting, else no grant). Leave LOCKw per the IDLE rules.

Boundary conditions:
- burst_cnt saturates at MAX_BURST while the other requester is idle; w keeps ownership indefinitely.
- MAX_BURST=1: a locked owner never blocks a waiting requester for more than one cycle.
- gnt0 and gnt1 are never both high (one-hot or zero).
- Request/lock changes take effect in the same cycle (combinational grant).
- Reset mid-burst: immediate return to IDLE and in-flight rvalid cleared. The pending read's data is discarded with no rvalid pulse.

Test Plan:
1. Reset low, then release; req0=1, we0=1, addr0=5, wdata0=0xA5 → gnt0=1 same cycle, mem_write=1, mem_addr=5. Next cycle req0=1, we0=0, addr0=5 → rvalid0=1 one cycle later with rdata0=0xA5.
2. req0=req1=1, reads, no lock, held 4 cycles → grants alternate 0,1,0,1. Never both gnt high.
3. MAX_BURST=4, lock1=1, req1 continuous, req0 raised at burst cycle 2 → gnt1 for 4 consecutive cycles, then gnt0 in cycle 5, then gnt1 again.
4. Locked owner 0 drops req0 while req1=1 → gnt1 in the same cycle, state leaves LOCK0.
5. Read granted, then reset asserted before the next clock edge → rvalid0 stays 0, all outputs 0. After release, first tie goes to requester 0 (PRIO_INIT=1).
